valve_sequencer: RTL
====================

VALVE_SEQUENCER -- requirements
Module: valve_sequencer

Interface
REQ-001 Parameter: BASE_CYCLES, 100000, clk cycles per base delay tick (1 ms at 100 MHz); legal range 1 or more.
REQ-002 Parameter: PROG_DEPTH, 100, number of valid instruction-memory words (addresses 0..PROG_DEPTH-1).
REQ-003 Port: clk  input  1  single system clock; all logic rising-edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle pulse that launches program execution from address 0.
REQ-006 Port: abort  input  1  one-cycle pulse that stops execution and returns to IDLE.
REQ-007 Port: Address  output  8  instruction-memory address; drives the asynchronous-read memory.
REQ-008 Port: ReadData1  input  13  instruction word returned combinationally for Address.
REQ-009 Port: valves  output  16  registered valve drive, bit n = valve n open.
REQ-010 Port: busy  output  1  high in FETCH, EXEC or DELAY.
REQ-011 Port: halted  output  1  high in HALTED.
REQ-012 Port: error  output  1  high in ERROR.

Function
REQ-013 Instruction decode: op = [12:10]; 000 HALT; 001 SET (valve index [9:6], value [0], bits [5:1] ignored); 010 DELAY (count [9:4], unit [3:1], bit [0] ignored); 011-111 illegal.
REQ-014 States: IDLE, FETCH, EXEC, DELAY, HALTED, ERROR; reset state IDLE.
REQ-015 IDLE/HALTED/ERROR + start -> FETCH, with Address <= 0 on the same edge; valves unchanged by start.
REQ-016 start is ignored in FETCH, EXEC and DELAY.
REQ-017 FETCH: IR <= ReadData1, Address <= Address+1, next state EXEC; fetch takes exactly 1 cycle.
REQ-018 FETCH with Address >= PROG_DEPTH (run off end without HALT) -> ERROR; IR not loaded.
REQ-019 EXEC SET: valves[index] <= value, other bits unchanged, next state FETCH (SET costs 2 cycles total).
REQ-020 EXEC DELAY: unit multiplier M = 1, 10, 100, 1000 for unit 000, 001, 010, 011; load tick counter with count*M and prescaler with BASE_CYCLES-1; next state DELAY.
REQ-021 EXEC DELAY with unit 100-111 -> ERROR.
REQ-022 EXEC DELAY with count = 0 -> FETCH directly (zero-length delay, 2 cycles total).
REQ-023 DELAY: prescaler decrements each cycle; at 0 it reloads BASE_CYCLES-1 and the tick counter decrements; when the tick counter reaches 0, next state FETCH.
REQ-024 DELAY occupies exactly count*M*BASE_CYCLES cycles; tick counter 16 bits (max 63*1000 = 63000).
REQ-025 EXEC HALT -> HALTED; valves hold their last value; Address holds (points one past the HALT).
REQ-026 EXEC illegal opcode -> ERROR.
REQ-027 Entry to ERROR clears valves to 0 on the same edge (fail-safe).
REQ-028 abort in any state -> IDLE next cycle, valves <= 0, Address <= 0, counters cleared; abort has priority over start and over state transitions.
REQ-029 start and abort asserted together: abort wins, start is discarded.
REQ-030 busy, halted and error are decoded directly from the registered state; at most one is high.

Reset
REQ-031 reset has priority over abort and start; on the reset edge: state IDLE, Address 0, valves 0, IR 0, prescaler 0, tick counter 0, busy/halted/error 0.
REQ-032 Reset mid-DELAY or mid-EXEC discards the in-flight instruction; no valve write occurs on the reset edge.

Verification (bench uses BASE_CYCLES=1 and a behavioural memory model)
REQ-033 Program {SET v1=1; DELAY count 3 unit 001; SET v1=0; HALT}, start at cycle 0 -> valves=0x0002 after cycle 2, held 2+30 cycles, then 0x0000; halted=1; Address=4.
REQ-034 Program {DELAY count 0; SET v15=1; HALT} -> valves=0x8000 at cycle 4; DELAY contributes 2 cycles only.
REQ-035 Word 13'b111_0000_00000_0 at address 1 after SET v3=1 -> error=1, valves=0x0000, busy=0; a subsequent start restarts from Address 0.
REQ-036 DELAY unit 101 -> ERROR; PROG_DEPTH=3 with no HALT in 0..2 -> ERROR on the 4th fetch attempt.
REQ-037 abort asserted 5 cycles into a 100-cycle DELAY with valves=0x0011 -> IDLE next cycle, valves=0, Address=0; start+abort in the same cycle -> stays IDLE.
REQ-038 reset during DELAY -> all outputs at reset values next cycle; start during busy -> no effect on Address or the timing of the running program.

Source files
------------

// File: rtl/valve_sequencer.sv
// valve_sequencer
//   Runs a small valve program held in an external asynchronous-read
//   instruction memory. Each word is HALT, SET (open/close one valve) or
//   DELAY (wait count * unit-multiplier base ticks). Errors and aborts drive
//   every valve closed.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      pulse: run program from address 0 (IDLE/HALTED/ERROR only)
//   abort      pulse: stop, close all valves, return to IDLE
//   Address    instruction-memory address
//   ReadData1  instruction word for Address (combinational)
//   valves     registered valve drive, bit n = valve n open
//   busy       FETCH, EXEC or DELAY
//   halted     HALTED
//   error      ERROR
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | after reset or abort, waiting for start
// FETCH   | latch the word at Address into IR, advance Address
// EXEC    | decode IR: SET, DELAY, HALT or fault
// DELAY   | prescaler/tick down-counters running
// HALTED  | HALT executed, valves hold, waiting for start
// ERROR   | fault seen, valves forced closed, waiting for start

module valve_sequencer #(
  parameter int BASE_CYCLES = 100000,
  parameter int PROG_DEPTH  = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  Address,
  input  logic [12:0] ReadData1,
  output logic [15:0] valves,
  output logic        busy,
  output logic        halted,
  output logic        error
);

  localparam int PW = (BASE_CYCLES > 1) ? $clog2(BASE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_RELOAD = PW'(BASE_CYCLES - 1);
  // one extra bit so a depth of 256 never wraps the compare
  localparam logic [8:0] DEPTH_LIM = 9'(PROG_DEPTH);

  localparam logic [2:0] OP_HALT  = 3'b000;
  localparam logic [2:0] OP_SET   = 3'b001;
  localparam logic [2:0] OP_DELAY = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DELAY,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [12:0]   ir_q, ir_d;
  logic [15:0]   valves_q, valves_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   tick_q, tick_d;

  logic [2:0]  op;
  logic [3:0]  set_idx;
  logic        set_val;
  logic [5:0]  dly_cnt;
  logic [2:0]  dly_unit;
  logic [15:0] dly_ticks;

  assign op       = ir_q[12:10];
  assign set_idx  = ir_q[9:6];
  assign set_val  = ir_q[0];
  assign dly_cnt  = ir_q[9:4];
  assign dly_unit = ir_q[3:1];

  // count * {1,10,100,1000}; 63 * 1000 still fits in 16 bits
  always_comb begin
    dly_ticks = 16'd0;
    case (dly_unit)
      3'b000:  dly_ticks = 16'(dly_cnt);
      3'b001:  dly_ticks = 16'(dly_cnt) * 16'd10;
      3'b010:  dly_ticks = 16'(dly_cnt) * 16'd100;
      3'b011:  dly_ticks = 16'(dly_cnt) * 16'd1000;
      default: dly_ticks = 16'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= 8'd0;
      ir_q     <= 13'd0;
      valves_q <= 16'd0;
      presc_q  <= '0;
      tick_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ir_q     <= ir_d;
      valves_q <= valves_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ir_d     = ir_q;
    valves_d = valves_q;
    presc_d  = presc_q;
    tick_d   = tick_q;

    if (abort) begin
      state_d  = S_IDLE;
      addr_d   = 8'd0;
      valves_d = 16'd0;
      presc_d  = '0;
      tick_d   = 16'd0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED, S_ERROR: begin
          if (start) begin
            state_d = S_FETCH;
            addr_d  = 8'd0;
          end
        end

        S_FETCH: begin
          // ran past the last program word without a HALT
          if ({1'b0, addr_q} >= DEPTH_LIM) begin
            state_d  = S_ERROR;
            valves_d = 16'd0;
          end else begin
            ir_d    = ReadData1;
            addr_d  = addr_q + 8'd1;
            state_d = S_EXEC;
          end
        end

        S_EXEC: begin
          case (op)
            OP_HALT: state_d = S_HALTED;
            OP_SET: begin
              valves_d[set_idx] = set_val;
              state_d           = S_FETCH;
            end
            OP_DELAY: begin
              if (dly_unit[2]) begin
                state_d  = S_ERROR;
                valves_d = 16'd0;
              end else if (dly_cnt == 6'd0) begin
                state_d = S_FETCH;
              end else begin
                tick_d  = dly_ticks;
                presc_d = PRESC_RELOAD;
                state_d = S_DELAY;
              end
            end
            default: begin
              state_d  = S_ERROR;
              valves_d = 16'd0;
            end
          endcase
        end

        S_DELAY: begin
          // leave on the edge where the last tick expires, so the state
          // is held for exactly ticks * BASE_CYCLES cycles
          if (presc_q == '0) begin
            presc_d = PRESC_RELOAD;
            tick_d  = tick_q - 16'd1;
            if (tick_q == 16'd1) begin
              state_d = S_FETCH;
            end
          end else begin
            presc_d = presc_q - 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign Address = addr_q;
  assign valves  = valves_q;
  assign busy    = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_DELAY);
  assign halted  = (state_q == S_HALTED);
  assign error   = (state_q == S_ERROR);

endmodule
